// File: rtl/gf180mcu_ocd_io_pwrseq_pkg.sv
// Shared types for the pad-ring power sequencer: state encodings
// and counter widths.
package gf180mcu_ocd_io_pwrseq_pkg;

    localparam int DEB_W = 8;
    localparam int SET_W = 10;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_VDD  = 3'd1,
        ST_WAIT_DVDD = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_ON        = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

endpackage

// File: rtl/gf180mcu_ocd_io__sync.sv
// Single-bit multi-flop synchronizer for asynchronous level-detector
// inputs; cleared by the synchronous reset.
module gf180mcu_ocd_io__sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gf180mcu_ocd_io__pwrseq.sv
// Pad-ring power sequencer: debounces core/IO rail-good, settles, then
// releases pad OE and core reset. GF180MCU_OCD_IO_PWRSEQ_FAULT_LATCH_EN latches rail loss.
module gf180mcu_ocd_io__pwrseq
    import gf180mcu_ocd_io_pwrseq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SETTLE_CYC   = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VDD_OK,
    input  logic       DVDD_OK,
    input  logic       FLT_CLR,
    output logic       PAD_OE_EN,
    output logic       CORE_RSTN,
    output logic [2:0] STATE,
    output logic       FAULT
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    logic vdd_s;
    logic dvdd_s;
    logic rails_ok;

    state_t            state;
    state_t            next;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_nxt;
    logic [SET_W-1:0]  set_cnt;
    logic [SET_W-1:0]  set_nxt;
    logic              pad_q;
    logic              rstn_q;

    gf180mcu_ocd_io__sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync_vdd (
        .clk(CLK),
        .rst(RST),
        .d  (VDD_OK),
        .q  (vdd_s)
    );

    gf180mcu_ocd_io__sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync_dvdd (
        .clk(CLK),
        .rst(RST),
        .d  (DVDD_OK),
        .q  (dvdd_s)
    );

    assign rails_ok = vdd_s & dvdd_s;

    always_comb begin
        next    = state;
        deb_nxt = deb_cnt;
        set_nxt = set_cnt;
        case (state)
            ST_OFF: begin
                next = ST_WAIT_VDD;
            end
            ST_WAIT_VDD: begin
                if (!vdd_s) begin
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    next = ST_WAIT_DVDD;
                end else if (deb_cnt != '1) begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            ST_WAIT_DVDD: begin
                if (!vdd_s) begin
                    next = ST_WAIT_VDD;
                end else if (!dvdd_s) begin
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    next = ST_SETTLE;
                end else if (deb_cnt != '1) begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!rails_ok) begin
                    next = ST_WAIT_VDD;
                end else if (set_cnt == SET_LAST) begin
                    next = ST_ON;
                end else if (set_cnt != '1) begin
                    set_nxt = set_cnt + 1'b1;
                end
            end
            ST_ON: begin
                if (!rails_ok) begin
`ifdef GF180MCU_OCD_IO_PWRSEQ_FAULT_LATCH_EN
                    next = ST_FAULT;
`else
                    next = ST_WAIT_VDD;
`endif
                end
            end
            ST_FAULT: begin
`ifdef GF180MCU_OCD_IO_PWRSEQ_FAULT_LATCH_EN
                // a rail still low blocks the clear
                if (FLT_CLR && rails_ok) begin
                    next = ST_WAIT_VDD;
                end
`else
                next = ST_OFF;
`endif
            end
            default: begin
                next = ST_OFF;
            end
        endcase
        if (next != state) begin
            deb_nxt = '0;
            set_nxt = '0;
        end
    end

    // Outputs are registered alongside the state so they switch on the
    // same edge the state leaves or enters ON.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_OFF;
            deb_cnt <= '0;
            set_cnt <= '0;
            pad_q   <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state   <= next;
            deb_cnt <= deb_nxt;
            set_cnt <= set_nxt;
            pad_q   <= (next == ST_ON);
            rstn_q  <= (next == ST_ON) && (state == ST_ON);
        end
    end

`ifdef GF180MCU_OCD_IO_PWRSEQ_FAULT_LATCH_EN
    logic fault_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (next == ST_FAULT);
        end
    end

    assign FAULT = fault_q;
`else
    logic unused_flt_clr;

    assign unused_flt_clr = FLT_CLR;
    assign FAULT          = 1'b0;
`endif

    assign PAD_OE_EN = pad_q;
    assign CORE_RSTN = rstn_q;
    assign STATE     = state;

endmodule

// File: doc/gf180mcu_ocd_io__pwrseq.md
GF180MCU_OCD_IO__PWRSEQ -- requirements
Module: gf180mcu_ocd_io__pwrseq

Interface
- REQ-001: Parameter SYNC_STAGES, default 2, number of synchronizer flops per rail-good input; legal range 2..4.
- REQ-002: Parameter DEBOUNCE_CYC, default 16, consecutive CLK cycles a rail-good must stay high to be accepted; legal range 1..255.
- REQ-003: Parameter SETTLE_CYC, default 64, CLK cycles from both rails accepted to IO release; legal range 1..1023.
- REQ-004: CLK  input  1  sole clock, rising edge.
- REQ-005: RST  input  1  reset, synchronous, active-high.
- REQ-006: VDD_OK  input  1  asynchronous core-rail level-detector output, high = good.
- REQ-007: DVDD_OK  input  1  asynchronous IO-rail level-detector output, high = good.
- REQ-008: FLT_CLR  input  1  synchronous fault-clear request, sampled high for one cycle.
- REQ-009: PAD_OE_EN  output  1  global pad-ring output-enable gate, high = pads may drive.
- REQ-010: CORE_RSTN  output  1  core reset, active-low, released one cycle after PAD_OE_EN rises.
- REQ-011: STATE  output  3  current FSM state encoding.
- REQ-012: FAULT  output  1  high while in FAULT state.

Function
- REQ-013: VDD_OK and DVDD_OK each pass through a SYNC_STAGES-deep flop chain before any use.
- REQ-014: FSM states and encodings: OFF=0, WAIT_VDD=1, WAIT_DVDD=2, SETTLE=3, ON=4, FAULT=5; encodings 6,7 unreachable and decode to OFF next cycle.
- REQ-015: OFF -> WAIT_VDD unconditionally on the first cycle after reset deasserts.
- REQ-016: WAIT_VDD: debounce counter increments each cycle synced VDD_OK is high, clears to 0 on any low cycle; on reaching DEBOUNCE_CYC-1 with VDD_OK high, go to WAIT_DVDD and clear counter.
- REQ-017: WAIT_DVDD: same debounce rule on synced DVDD_OK; synced VDD_OK low returns to WAIT_VDD with counter cleared; on acceptance go to SETTLE.
- REQ-018: SETTLE: settle counter counts 0..SETTLE_CYC-1, then ON; either synced rail low returns to WAIT_VDD.
- REQ-019: ON: PAD_OE_EN=1; CORE_RSTN=1 from the second ON cycle onward.
- REQ-020: In ON, either synced rail low deasserts PAD_OE_EN and CORE_RSTN in the same cycle the state leaves ON (combinational from next-state is forbidden; outputs registered, one cycle after synced drop).
- REQ-021: Debounce counter 8 bits, settle counter 10 bits; neither wraps: both saturate and are cleared on every state change.
- REQ-022: Simultaneous rail drop and FLT_CLR: rail drop wins.
- REQ-023: PAD_OE_EN and CORE_RSTN are low in every state except ON.

Reset
- REQ-024: RST high for one cycle forces state OFF, counters 0, synchronizer flops 0, PAD_OE_EN=0, CORE_RSTN=0, FAULT=0, STATE=0.
- REQ-025: RST asserted mid-sequence, including in ON, takes effect on the next CLK edge with no drain.

Configuration
- REQ-026: Macro GF180MCU_OCD_IO_PWRSEQ_FAULT_LATCH_EN defined: rail loss in ON goes to FAULT; FAULT holds outputs low until FLT_CLR is high with both synced rails high, then goes to WAIT_VDD.
- REQ-027: Macro undefined: rail loss in ON goes directly to WAIT_VDD, FAULT is tied 0, FLT_CLR is ignored, state FAULT is unreachable.

Structure
- REQ-028: Shared package gf180mcu_ocd_io_pwrseq_pkg holds the state typedef and encodings, counter width constants.
- REQ-029: One sub-module gf180mcu_ocd_io__sync, a parameterized single-bit synchronizer, instantiated twice.

Verification
- REQ-030: Reset, both rails high from cycle 0, defaults -> PAD_OE_EN rises exactly 2+16+16+64+(state-transition cycles) later, as computed per REQ-015..018; CORE_RSTN rises one cycle after.
- REQ-031: VDD_OK glitch low for 1 cycle at debounce count 10 -> counter restarts, WAIT_DVDD entered 16 cycles after glitch ends.
- REQ-032: DVDD_OK drops during SETTLE count 30 -> state WAIT_VDD, PAD_OE_EN stays 0.
- REQ-033: FAULT_LATCH_EN defined, DVDD_OK drops in ON -> FAULT=1, outputs 0; FLT_CLR with rails good -> WAIT_VDD, full resequence.
- REQ-034: FAULT_LATCH_EN undefined, same drop -> WAIT_VDD directly, FAULT stays 0, automatic resequence.
- REQ-035: RST pulsed while in ON -> next cycle STATE=0, PAD_OE_EN=0, CORE_RSTN=0.
